// File: rtl/encoder_16_to_4_seq.sv
// Sequential 16-to-4 priority encoder. Rising edges on D become pending requests,
// and the highest pending index is presented on Y with a VALID/ACK handshake.
module encoder_16_to_4_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] D,
  input  logic        EN,
  input  logic        CLR,
  input  logic        ACK,
  output logic [3:0]  Y,
  output logic        VALID,
  output logic [15:0] PEND,
  output logic        ERR
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  y_q, y_d;
  logic [15:0] pend_q, pend_d;
  logic        err_q, err_d;
  logic [15:0] dq_q;

  logic [15:0] rise;
  logic [15:0] merged;
  logic [15:0] cand;
  logic [3:0]  topIdx;
  logic        issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      pend_q  <= '0;
      err_q   <= '0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      dq_q    <= D;
    end
  end

  // A rise on the code still being presented (and not taken this edge) folds into it.
  always_comb begin
    rise   = D & ~dq_q;
    merged = '0;
    if (state_q == HOLD && !ACK) merged = 16'(1) << y_q;
    cand   = CLR ? '0 : (pend_q | (rise & ~merged));
    topIdx = '0;
    for (int i = 0; i < 16; i++) begin
      if (cand[i]) topIdx = 4'(i);
    end
    issue = EN && (|cand) && (state_q == IDLE || ACK);
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    pend_d  = cand;
    err_d   = CLR ? 1'b0 : (err_q | (|(rise & pend_q)) | (|(rise & merged)));
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = HOLD;
          y_d     = topIdx;
          pend_d  = cand & ~(16'(1) << topIdx);
        end
      end
      HOLD: begin
        if (ACK) begin
          if (issue) begin
            y_d    = topIdx;
            pend_d = cand & ~(16'(1) << topIdx);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Y     = y_q;
  assign VALID = (state_q == HOLD);
  assign PEND  = pend_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_encoder_16_to_4_seq.sv
// Scenario bench for encoder_16_to_4_seq: expected codes are queued when requests
// are driven and compared when the DUT hands them over (VALID and ACK together).
module tb_encoder_16_to_4_seq;

  logic        clk;
  logic        rst;
  logic [15:0] D;
  logic        EN;
  logic        CLR;
  logic        ACK;
  logic [3:0]  Y;
  logic        VALID;
  logic [15:0] PEND;
  logic        ERR;

  int nChecks = 0;
  int nFails  = 0;
  logic [3:0] expQ[$];

  encoder_16_to_4_seq dut (
    .clk   (clk),
    .rst   (rst),
    .D     (D),
    .EN    (EN),
    .CLR   (CLR),
    .ACK   (ACK),
    .Y     (Y),
    .VALID (VALID),
    .PEND  (PEND),
    .ERR   (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Handshake monitor: each accepted code must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && VALID === 1'b1 && ACK === 1'b1) begin
      nChecks++;
      if (expQ.size() == 0) begin
        nFails++;
        $display("[TB] FAIL handshake: Y=%0d accepted with nothing expected", Y);
      end else begin
        logic [3:0] e;
        e = expQ.pop_front();
        if (Y !== e) begin
          nFails++;
          $display("[TB] FAIL handshake_y: got %0d expected %0d", Y, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; D = '0; EN = 1'b0; CLR = 1'b0; ACK = 1'b0;
    tick(); tick();
    rst = 1'b0;
    nChecks++; if (Y !== 4'd0)      begin nFails++; $display("[TB] FAIL reset_y: got %0d expected 0", Y); end
    nChecks++; if (VALID !== 1'b0)  begin nFails++; $display("[TB] FAIL reset_valid: got %b expected 0", VALID); end
    nChecks++; if (PEND !== 16'h0)  begin nFails++; $display("[TB] FAIL reset_pend: got %h expected 0000", PEND); end
    nChecks++; if (ERR !== 1'b0)    begin nFails++; $display("[TB] FAIL reset_err: got %b expected 0", ERR); end
  endtask

  task automatic test_single();
    EN = 1'b1; D = 16'h0008; expQ.push_back(4'd3);
    tick();
    nChecks++; if (VALID !== 1'b1) begin nFails++; $display("[TB] FAIL single_valid: got %b expected 1", VALID); end
    nChecks++; if (Y !== 4'd3)     begin nFails++; $display("[TB] FAIL single_y: got %0d expected 3", Y); end
    nChecks++; if (PEND !== 16'h0) begin nFails++; $display("[TB] FAIL single_pend: got %h expected 0000", PEND); end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    nChecks++; if (VALID !== 1'b0) begin nFails++; $display("[TB] FAIL single_ack_valid: got %b expected 0", VALID); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++; if (VALID !== 1'b0) begin nFails++; $display("[TB] FAIL single_level_held: cycle %0d VALID=%b expected 0", i, VALID); end
    end
    D = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] expPend[3];
    expPend[0] = 16'h0101; expPend[1] = 16'h0001; expPend[2] = 16'h0000;
    EN = 1'b1; ACK = 1'b1; D = 16'h8101;
    expQ.push_back(4'd15); expQ.push_back(4'd8); expQ.push_back(4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++; if (VALID !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_valid: cycle %0d got %b expected 1", i, VALID); end
      nChecks++; if (PEND !== expPend[i]) begin nFails++; $display("[TB] FAIL b2b_pend: cycle %0d got %h expected %h", i, PEND, expPend[i]); end
    end
    tick();
    nChecks++; if (VALID !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_end_valid: got %b expected 0", VALID); end
    nChecks++; if (PEND !== 16'h0) begin nFails++; $display("[TB] FAIL b2b_end_pend: got %h expected 0000", PEND); end
    ACK = 1'b0; D = '0;
    tick();
  endtask

  task automatic test_hold();
    EN = 1'b1; ACK = 1'b0; D = 16'h0030;
    expQ.push_back(4'd5); expQ.push_back(4'd4);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      nChecks++; if (VALID !== 1'b1 || Y !== 4'd5) begin nFails++; $display("[TB] FAIL hold_code: cycle %0d VALID=%b Y=%0d expected 1/5", i, VALID, Y); end
      nChecks++; if (PEND !== 16'h0010) begin nFails++; $display("[TB] FAIL hold_pend: cycle %0d got %h expected 0010", i, PEND); end
    end
    ACK = 1'b1;
    tick();
    nChecks++; if (Y !== 4'd4 || VALID !== 1'b1) begin nFails++; $display("[TB] FAIL hold_next: Y=%0d VALID=%b expected 4/1", Y, VALID); end
    tick();
    ACK = 1'b0; D = '0;
    tick();
  endtask

  task automatic test_overflow();
    EN = 1'b0; D = 16'h0004;
    tick();
    D = '0;
    tick();
    D = 16'h0004;
    tick();
    nChecks++; if (ERR !== 1'b1)      begin nFails++; $display("[TB] FAIL ovf_err: got %b expected 1", ERR); end
    nChecks++; if (PEND !== 16'h0004) begin nFails++; $display("[TB] FAIL ovf_pend: got %h expected 0004", PEND); end
    nChecks++; if (VALID !== 1'b0)    begin nFails++; $display("[TB] FAIL ovf_valid: got %b expected 0", VALID); end
    CLR = 1'b1;
    tick();
    CLR = 1'b0; D = '0;
    nChecks++; if (ERR !== 1'b0)   begin nFails++; $display("[TB] FAIL clr_err: got %b expected 0", ERR); end
    nChecks++; if (PEND !== 16'h0) begin nFails++; $display("[TB] FAIL clr_pend: got %h expected 0000", PEND); end
    tick();
  endtask

  task automatic test_ack_rerise();
    EN = 1'b1; ACK = 1'b0; D = 16'h0002; expQ.push_back(4'd1);
    tick();
    D = '0;
    tick();
    D = 16'h0002; ACK = 1'b1; expQ.push_back(4'd1);
    tick();
    ACK = 1'b0;
    nChecks++; if (VALID !== 1'b1 || Y !== 4'd1) begin nFails++; $display("[TB] FAIL rerise_code: VALID=%b Y=%0d expected 1/1", VALID, Y); end
    nChecks++; if (ERR !== 1'b0) begin nFails++; $display("[TB] FAIL rerise_err: got %b expected 0", ERR); end
    D = '0;
    tick();
    D = 16'h0002;
    tick();
    nChecks++; if (ERR !== 1'b1)   begin nFails++; $display("[TB] FAIL dup_presented_err: got %b expected 1", ERR); end
    nChecks++; if (PEND !== 16'h0) begin nFails++; $display("[TB] FAIL dup_presented_pend: got %h expected 0000", PEND); end
    ACK = 1'b1;
    tick();
    ACK = 1'b0; CLR = 1'b1;
    nChecks++; if (VALID !== 1'b0) begin nFails++; $display("[TB] FAIL dup_drain_valid: got %b expected 0", VALID); end
    tick();
    CLR = 1'b0; D = '0;
    tick();
    nChecks++; if (ERR !== 1'b0) begin nFails++; $display("[TB] FAIL dup_clr_err: got %b expected 0", ERR); end
  endtask

  task automatic test_en_gating();
    EN = 1'b0; ACK = 1'b0; D = 16'h0042;
    tick(); tick();
    nChecks++; if (VALID !== 1'b0)    begin nFails++; $display("[TB] FAIL engate_valid: got %b expected 0", VALID); end
    nChecks++; if (PEND !== 16'h0042) begin nFails++; $display("[TB] FAIL engate_pend: got %h expected 0042", PEND); end
    EN = 1'b1; expQ.push_back(4'd6); expQ.push_back(4'd1);
    tick();
    nChecks++; if (Y !== 4'd6 || VALID !== 1'b1) begin nFails++; $display("[TB] FAIL engate_issue: Y=%0d VALID=%b expected 6/1", Y, VALID); end
    ACK = 1'b1;
    tick(); tick();
    ACK = 1'b0; D = '0;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    EN = 1'b0; ACK = 1'b0; D = 16'h00F0;
    tick();
    D = '0;
    tick();
    EN = 1'b1; D = 16'h0100; expQ.push_back(4'd8);
    tick();
    D = 16'h0110;
    tick();
    nChecks++; if (VALID !== 1'b1 || Y !== 4'd8 || PEND !== 16'h00F0 || ERR !== 1'b1) begin
      nFails++; $display("[TB] FAIL midhold_setup: VALID=%b Y=%0d PEND=%h ERR=%b expected 1/8/00f0/1", VALID, Y, PEND, ERR);
    end
    rst = 1'b1; D = 16'h0200; ACK = 1'b1; CLR = 1'b1; expQ.delete();
    tick();
    rst = 1'b0; ACK = 1'b0; CLR = 1'b0;
    nChecks++; if (VALID !== 1'b0 || Y !== 4'd0 || PEND !== 16'h0 || ERR !== 1'b0) begin
      nFails++; $display("[TB] FAIL midhold_reset: VALID=%b Y=%0d PEND=%h ERR=%b expected all 0", VALID, Y, PEND, ERR);
    end
    expQ.push_back(4'd9);
    tick();
    nChecks++; if (VALID !== 1'b1 || Y !== 4'd9) begin nFails++; $display("[TB] FAIL midhold_release: VALID=%b Y=%0d expected 1/9", VALID, Y); end
    ACK = 1'b1;
    tick();
    ACK = 1'b0; D = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_overflow();
    test_ack_rerise();
    test_en_gating();
    test_reset_mid_hold();
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard_drain: %0d codes never delivered, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
